// File: rtl/hazard_ctrl_pipe.sv
// Hazard unit with E/M/W control pipeline for a 5-stage RISC-V core.
// Handles load-use stalls, branch flushes, operand forwarding and memory-wait stalls with a timeout flag.
module hazard_ctrl_pipe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RegWriteD,
    input  logic       MemWriteD,
    input  logic       JumpD,
    input  logic       BranchD,
    input  logic       ALUSrcD,
    input  logic [1:0] ResultSrcD,
    input  logic [1:0] ALUOpD,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] RdD,
    input  logic       ZeroE,
    input  logic       mem_ready,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD,
    output logic       FlushE,
    output logic       PCSrcE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       ALUSrcE,
    output logic [1:0] ALUOpE,
    output logic       MemWriteM,
    output logic       RegWriteW,
    output logic [1:0] ResultSrcW,
    output logic [4:0] RdW,
    output logic       mem_timeout
);

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic [1:0] alu_op;
        logic [4:0] rd;
    } ctrl_t;

    localparam logic [1:0] RES_LOAD = 2'b01;

    ctrl_t      r_e;
    ctrl_t      r_m;
    ctrl_t      r_w;
    logic [4:0] r_rs1_e;
    logic [4:0] r_rs2_e;
    logic [3:0] r_wait_cnt;
    logic       r_mem_timeout;

    ctrl_t      w_ctrl_d;
    logic       w_mem_stall;
    logic       w_lw_stall;
    logic       w_pcsrc;
    logic       w_flush_e;
    logic       w_unused;

    assign w_ctrl_d = '{RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcD, ALUOpD, RdD};

    assign w_mem_stall = (r_m.mem_write | (r_m.result_src == RES_LOAD)) & ~mem_ready;
    assign w_lw_stall  = (r_e.result_src == RES_LOAD) & (r_e.rd != 5'd0)
                       & ((r_e.rd == Rs1D) | (r_e.rd == Rs2D));
    assign w_pcsrc     = r_e.jump | (r_e.branch & ZeroE);
    assign w_flush_e   = (w_lw_stall | w_pcsrc) & ~w_mem_stall;

    // M result beats W result; x0 is never a forwarding source.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input ctrl_t m, input ctrl_t w);
        if (m.reg_write && (m.rd != 5'd0) && (m.rd == rs))
            return 2'b10;
        else if (w.reg_write && (w.rd != 5'd0) && (w.rd == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // NOTE: state registers use <= so every stage samples the pre-edge value of its predecessor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e     <= '0;
            r_m     <= '0;
            r_w     <= '0;
            r_rs1_e <= '0;
            r_rs2_e <= '0;
        end else if (w_mem_stall) begin
            r_w <= '0;
        end else begin
            r_m <= r_e;
            r_w <= r_m;
            if (w_flush_e) begin
                r_e     <= '0;
                r_rs1_e <= '0;
                r_rs2_e <= '0;
            end else begin
                r_e     <= w_ctrl_d;
                r_rs1_e <= Rs1D;
                r_rs2_e <= Rs2D;
            end
        end
    end

    // Wait counter saturates so a stuck access keeps the sticky flag asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else if (w_mem_stall) begin
            if (r_wait_cnt == 4'd15)
                r_mem_timeout <= 1'b1;
            else
                r_wait_cnt <= r_wait_cnt + 4'd1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    assign StallF      = w_lw_stall | w_mem_stall;
    assign StallD      = w_lw_stall | w_mem_stall;
    assign FlushD      = w_pcsrc & ~w_mem_stall;
    assign FlushE      = w_flush_e;
    assign PCSrcE      = w_pcsrc;
    assign ForwardAE   = fwd_sel(r_rs1_e, r_m, r_w);
    assign ForwardBE   = fwd_sel(r_rs2_e, r_m, r_w);
    assign ALUSrcE     = r_e.alu_src;
    assign ALUOpE      = r_e.alu_op;
    assign MemWriteM   = r_m.mem_write;
    assign RegWriteW   = r_w.reg_write;
    assign ResultSrcW  = r_w.result_src;
    assign RdW         = r_w.rd;
    assign mem_timeout = r_mem_timeout;

    assign w_unused = ^{r_w.mem_write, r_w.jump, r_w.branch, r_w.alu_src, r_w.alu_op};

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Scoreboard bench for hazard_ctrl_pipe: a stage-record reference model predicts every cycle's outputs,
// a negedge monitor compares them; directed scenarios cover load-use, forwarding, branch, memory wait and reset.
module tb_hazard_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
    logic [1:0] ResultSrcD, ALUOpD;
    logic [4:0] Rs1D, Rs2D, RdD;
    logic       ZeroE, mem_ready;
    logic       StallF, StallD, FlushD, FlushE, PCSrcE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       ALUSrcE;
    logic [1:0] ALUOpE;
    logic       MemWriteM, RegWriteW;
    logic [1:0] ResultSrcW;
    logic [4:0] RdW;
    logic       mem_timeout;

    always #5 clk = ~clk;

    hazard_ctrl_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
        .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUOpD(ALUOpD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE), .mem_ready(mem_ready),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE), .PCSrcE(PCSrcE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ALUSrcE(ALUSrcE), .ALUOpE(ALUOpE),
        .MemWriteM(MemWriteM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
        .mem_timeout(mem_timeout)
    );

    typedef struct packed {
        logic       rw;
        logic [1:0] rsrc;
        logic       mw;
        logic       j;
        logic       br;
        logic       as;
        logic [1:0] aop;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } instr_t;

    logic [21:0] w_act;
    assign w_act = {StallF, StallD, FlushD, FlushE, PCSrcE, ForwardAE, ForwardBE, ALUSrcE, ALUOpE,
                    MemWriteM, RegWriteW, ResultSrcW, RdW, mem_timeout};

    // Reference model: the instruction record occupying each stage, plus memory-wait bookkeeping.
    instr_t      m_e, m_m, m_w;
    int          m_wait;
    bit          m_timeout;
    logic [21:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;
    instr_t      nop = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic instr_t mk(input bit rw, input bit [1:0] rsrc, input bit mw, input bit j,
                                  input bit br, input bit as, input bit [1:0] aop,
                                  input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2);
        return '{rw, rsrc, mw, j, br, as, aop, rd, rs1, rs2};
    endfunction

    function automatic instr_t rand_instr();
        return mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)));
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (m_m.rw && m_m.rd != 0 && m_m.rd == rs) return 2'b10;
        if (m_w.rw && m_w.rd != 0 && m_w.rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic drive(input instr_t d, input logic z, input logic r);
        RegWriteD = d.rw; ResultSrcD = d.rsrc; MemWriteD = d.mw; JumpD = d.j; BranchD = d.br;
        ALUSrcD = d.as; ALUOpD = d.aop; RdD = d.rd; Rs1D = d.rs1; Rs2D = d.rs2;
        ZeroE = z; mem_ready = r;
    endtask

    task automatic model_reset();
        m_e = '0; m_m = '0; m_w = '0; m_wait = 0; m_timeout = 0;
    endtask

    // One clock cycle: drive inputs after the edge, queue the predicted outputs, advance the model.
    task automatic step(input instr_t d, input logic z, input logic r);
        bit ms, lw, pc;
        @(posedge clk);
        #1;
        drive(d, z, r);
        ms = (m_m.mw || m_m.rsrc == 2'b01) && !r;
        lw = m_e.rsrc == 2'b01 && m_e.rd != 0 && (m_e.rd == d.rs1 || m_e.rd == d.rs2);
        pc = m_e.j || (m_e.br && z);
        exp_q.push_back({ms || lw, ms || lw, pc && !ms, (lw || pc) && !ms, pc,
                         m_fwd(m_e.rs1), m_fwd(m_e.rs2), m_e.as, m_e.aop, m_m.mw,
                         m_w.rw, m_w.rsrc, m_w.rd, m_timeout});
        if (ms) begin
            if (m_wait == 15) m_timeout = 1;
            m_wait = (m_wait < 15) ? m_wait + 1 : 15;
            m_w = '0;
        end else begin
            m_wait = 0;
            m_w = m_m;
            m_m = m_e;
            m_e = (lw || pc) ? '0 : d;
        end
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #1;
        drive(nop, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1 check("reset_outputs_zero", 32'(w_act), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) check("cycle_outputs", 32'(w_act), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        drive(nop, 1'b0, 1'b1);
        model_reset();
        #1 rst_n = 1'b0;
        reset_dut();

        for (int i = 0; i < 400; i++)
            step(rand_instr(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        reset_dut();

        // Load-use on x5.
        step(mk(1, 2'b01, 0, 0, 0, 0, 2'b00, 5'd5, 5'd0, 5'd0), 0, 1);
        step(mk(1, 2'b00, 0, 0, 0, 0, 2'b10, 5'd6, 5'd5, 5'd0), 0, 1);
        check("loaduse_stall", {StallF, StallD, FlushE}, 3'b111);
        step(mk(1, 2'b00, 0, 0, 0, 0, 2'b10, 5'd6, 5'd5, 5'd0), 0, 1);
        check("loaduse_stall_released", {StallF, StallD, FlushE}, 3'b000);
        step(nop, 0, 1);
        check("loaduse_forward_w", ForwardAE, 2'b01);

        // M-stage forward on x7, then the same shape targeting x0.
        step(mk(1, 2'b00, 0, 0, 0, 0, 2'b10, 5'd7, 5'd0, 5'd0), 0, 1);
        step(mk(0, 2'b00, 0, 0, 0, 0, 2'b10, 5'd8, 5'd0, 5'd7), 0, 1);
        step(nop, 0, 1);
        check("fwd_m_rs2", ForwardBE, 2'b10);
        step(mk(1, 2'b00, 0, 0, 0, 0, 2'b10, 5'd0, 5'd0, 5'd0), 0, 1);
        step(mk(0, 2'b00, 0, 0, 0, 0, 2'b10, 5'd8, 5'd0, 5'd0), 0, 1);
        step(nop, 0, 1);
        check("fwd_x0_blocked", ForwardBE, 2'b00);

        // Taken branch.
        step(mk(0, 2'b00, 0, 0, 1, 0, 2'b01, 5'd0, 5'd1, 5'd2), 0, 1);
        step(mk(0, 2'b00, 1, 0, 0, 1, 2'b11, 5'd0, 5'd1, 5'd2), 1, 1);
        check("branch_taken", {PCSrcE, FlushD, FlushE}, 3'b111);
        step(nop, 0, 1);
        check("branch_bubble_aluop", ALUOpE, 2'b00);
        step(nop, 0, 1);
        check("branch_bubble_memwrite", MemWriteM, 1'b0);

        // Store waiting three cycles for memory.
        step(mk(0, 2'b00, 1, 0, 0, 1, 2'b00, 5'd0, 5'd1, 5'd2), 0, 1);
        step(nop, 0, 1);
        for (int k = 0; k < 3; k++) begin
            step(nop, 0, 0);
            check("memwait_held", {StallF, MemWriteM, RegWriteW}, 3'b110);
        end
        step(nop, 0, 1);
        check("memwait_released", StallF, 1'b0);

        // Load stuck for 17 cycles raises the sticky timeout.
        step(mk(1, 2'b01, 0, 0, 0, 0, 2'b00, 5'd3, 5'd0, 5'd0), 0, 1);
        step(nop, 0, 1);
        for (int k = 1; k <= 17; k++) begin
            step(nop, 0, 0);
            if (k == 16) check("timeout_not_yet", mem_timeout, 1'b0);
        end
        check("timeout_set", mem_timeout, 1'b1);
        for (int k = 0; k < 3; k++) step(nop, 0, 1);
        check("timeout_sticky", mem_timeout, 1'b1);

        // Store in M stalling, reset dropped between edges.
        step(mk(0, 2'b00, 1, 0, 0, 0, 2'b00, 5'd0, 5'd1, 5'd1), 0, 1);
        step(nop, 0, 1);
        @(posedge clk);
        #1 drive(mk(1, 2'b01, 0, 1, 1, 1, 2'b11, 5'd3, 5'd3, 5'd3), 1, 0);
        #1 check("stall_before_reset", {StallF, MemWriteM, mem_timeout}, 3'b111);
        #1 rst_n = 1'b0;
        #1 check("async_reset_outputs", 32'(w_act), 32'd0);
        drive(nop, 1'b0, 1'b1);
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        for (int i = 0; i < 150; i++)
            step(rand_instr(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));

        @(negedge clk);
        #1 check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
